// File: rtl/ls_unit_pkg.sv
// Shared load/store unit types: FU opcodes, unit state encoding, datapath widths.
package ls_unit_pkg;

    localparam int GPR_SIZE     = 64;
    localparam int ROB_IDX_SIZE = 5;

    localparam logic [2:0] LS_ALIGN_MASK = 3'b111;

    typedef enum logic [3:0] {
        FU_OP_ADD  = 4'd0,
        FU_OP_SUB  = 4'd1,
        FU_OP_LDUR = 4'd2,
        FU_OP_STUR = 4'd3,
        FU_OP_B    = 4'd4
    } fu_op_t;

    typedef enum logic [2:0] {
        LS_IDLE  = 3'd0,
        LS_REQ   = 3'd1,
        LS_WAIT  = 3'd2,
        LS_DRAIN = 3'd3,
        LS_DONE  = 3'd4
    } ls_state_t;

    function automatic logic ls_op_legal(input fu_op_t op);
        return (op == FU_OP_LDUR) || (op == FU_OP_STUR);
    endfunction

endpackage

// File: rtl/ls_unit.sv
// Single-outstanding LDUR/STUR unit: RS accept -> mem req/resp -> one-cycle ROB completion.
// Min latency 3 cycles (1 on alignment/op error); accepts only when idle, holds request until mem ready.
module ls_unit
    import ls_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_start,
    input  fu_op_t                  in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    output logic                    out_rs_ready,
    input  logic                    in_rob_is_mispred,
    output logic                    out_mem_req_valid,
    input  logic                    in_mem_req_ready,
    output logic                    out_mem_we,
    output logic [GPR_SIZE-1:0]     out_mem_addr,
    output logic [GPR_SIZE-1:0]     out_mem_wdata,
    input  logic                    in_mem_resp_valid,
    input  logic [GPR_SIZE-1:0]     in_mem_rdata,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_error
);

    ls_state_t                 state_q, state_d;
    logic                      is_store_q;
    logic [GPR_SIZE-1:0]       addr_q, wdata_q, value_q, value_d;
    logic [ROB_IDX_SIZE-1:0]   rob_q;
    logic                      error_q, error_d;
    logic [TIMEOUT_W-1:0]      cnt_q, cnt_d, cnt_sat;
    logic                      accept, bad_op, timed_out, latch_en;

    assign accept    = in_rs_start & (state_q == LS_IDLE) & ~in_rob_is_mispred;
    assign bad_op    = !ls_op_legal(in_rs_op) || ((in_rs_val_a[2:0] & LS_ALIGN_MASK) != 3'b000);
    assign timed_out = (cnt_q >= TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_sat   = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + TIMEOUT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        error_d  = error_q;
        latch_en = 1'b0;
        unique case (state_q)
            LS_IDLE: begin
                if (accept) begin
                    latch_en = 1'b1;
                    value_d  = '0;
                    error_d  = bad_op;
                    state_d  = bad_op ? LS_DONE : LS_REQ;
                end
            end
            LS_REQ: begin
                // A request the memory already took must still be drained.
                if (in_rob_is_mispred) begin
                    state_d = in_mem_req_ready ? LS_DRAIN : LS_IDLE;
                    cnt_d   = '0;
                end else if (in_mem_req_ready) begin
                    state_d = LS_WAIT;
                    cnt_d   = '0;
                end
            end
            LS_WAIT: begin
                cnt_d = cnt_sat;
                if (in_rob_is_mispred) begin
                    state_d = in_mem_resp_valid ? LS_IDLE : LS_DRAIN;
                end else if (in_mem_resp_valid) begin
                    state_d = LS_DONE;
                    value_d = is_store_q ? '0 : in_mem_rdata;
                    error_d = 1'b0;
                end else if (timed_out) begin
                    state_d = LS_DONE;
                    value_d = '0;
                    error_d = 1'b1;
                end
            end
            LS_DRAIN: begin
                cnt_d = cnt_sat;
                if (in_mem_resp_valid || timed_out) state_d = LS_IDLE;
            end
            LS_DONE:  state_d = LS_IDLE;
            default:  state_d = LS_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= LS_IDLE;
            cnt_q      <= '0;
            value_q    <= '0;
            error_q    <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rob_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            error_q <= error_d;
            if (latch_en) begin
                is_store_q <= (in_rs_op == FU_OP_STUR);
                addr_q     <= in_rs_val_a;
                wdata_q    <= in_rs_val_b;
                rob_q      <= in_rs_dst_rob_index;
            end
        end
    end

    assign out_rs_ready      = (state_q == LS_IDLE);
    assign out_mem_req_valid = (state_q == LS_REQ);
    assign out_mem_we        = out_mem_req_valid & is_store_q;
    assign out_mem_addr      = out_mem_req_valid ? addr_q : '0;
    assign out_mem_wdata     = out_mem_we ? wdata_q : '0;

    // Mispredict in DONE kills the completion pulse in the same cycle.
    assign out_rob_done          = (state_q == LS_DONE) & ~in_rob_is_mispred;
    assign out_rob_dst_rob_index = out_rob_done ? rob_q : '0;
    assign out_rob_value         = out_rob_done ? value_q : '0;
    assign out_rob_error         = out_rob_done & error_q;

endmodule
